// File: rtl/player_track_walker.sv
// Circular-track position engine: holds per-player tile and lap counts and walks
// one accepted player forward one tile per step_en tick, reporting landing status.
module player_track_walker #(
  parameter int N_PLAYERS = 4,
  parameter int TRACK_LEN = 24,
  parameter int POS_W     = 5,
  parameter int PID_W     = 2,
  parameter int STEP_W    = 3,
  parameter int LAP_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       step_en,
  input  logic                       move_valid,
  output logic                       move_ready,
  input  logic [PID_W-1:0]           move_pid,
  input  logic [STEP_W-1:0]          move_steps,
  output logic [N_PLAYERS*POS_W-1:0] pos_flat,
  output logic [N_PLAYERS*LAP_W-1:0] lap_flat,
  output logic                       busy,
  output logic                       move_done,
  output logic                       move_err,
  output logic                       land_shared
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t              state;
  logic [POS_W-1:0]    pos [N_PLAYERS];
  logic [LAP_W-1:0]    lap [N_PLAYERS];
  logic [PID_W-1:0]    pid_q;
  logic [STEP_W-1:0]   remaining;
  logic                pid_ok;
  logic                shared;
  logic [POS_W-1:0]    land_pos;

  assign pid_ok     = (int'(move_pid) < N_PLAYERS);
  assign move_ready = (state == IDLE) & ~clr;

  always_comb begin
    pos_flat = '0;
    lap_flat = '0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      pos_flat[k*POS_W +: POS_W] = pos[k];
      lap_flat[k*LAP_W +: LAP_W] = lap[k];
    end
  end

  // Occupancy check of the mover's tile; only meaningful for a valid pid in DONE.
  always_comb begin
    land_pos = '0;
    shared   = 1'b0;
    for (int k = 0; k < N_PLAYERS; k++)
      if (PID_W'(k) == pid_q) land_pos = pos[k];
    for (int k = 0; k < N_PLAYERS; k++)
      if ((PID_W'(k) != pid_q) && (pos[k] == land_pos)) shared = 1'b1;
  end

  assign land_shared = move_done & ~move_err & shared;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pid_q     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      move_done <= 1'b0;
      move_err  <= 1'b0;
      for (int k = 0; k < N_PLAYERS; k++) begin
        pos[k] <= '0;
        lap[k] <= '0;
      end
    end else if (clr) begin
      state     <= IDLE;
      busy      <= 1'b0;
      move_done <= 1'b0;
      move_err  <= 1'b0;
      for (int k = 0; k < N_PLAYERS; k++) begin
        pos[k] <= '0;
        lap[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          move_done <= 1'b0;
          move_err  <= 1'b0;
          if (move_valid) begin
            pid_q     <= move_pid;
            remaining <= move_steps;
            if ((move_steps != '0) && pid_ok) begin
              state <= WALK;
              busy  <= 1'b1;
            end else begin
              state     <= DONE;
              move_done <= 1'b1;
              move_err  <= ~pid_ok;
            end
          end
        end
        WALK: begin
          if (step_en) begin
            for (int k = 0; k < N_PLAYERS; k++) begin
              if (PID_W'(k) == pid_q) begin
                if (pos[k] == POS_W'(TRACK_LEN - 1)) begin
                  pos[k] <= '0;
                  if (lap[k] != '1) lap[k] <= lap[k] + 1'b1;
                end else begin
                  pos[k] <= pos[k] + 1'b1;
                end
              end
            end
            remaining <= remaining - 1'b1;
            if (remaining == STEP_W'(1)) begin
              state     <= DONE;
              busy      <= 1'b0;
              move_done <= 1'b1;
              move_err  <= 1'b0;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          move_done <= 1'b0;
          move_err  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          move_done <= 1'b0;
          move_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_track_walker.sv
// Directed bench for player_track_walker with three players so pid 3 is illegal.
module tb_player_track_walker;

  localparam int N      = 3;
  localparam int TLEN   = 24;
  localparam int POS_W  = 5;
  localparam int PID_W  = 2;
  localparam int STEP_W = 3;
  localparam int LAP_W  = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   clr = 1'b0;
  logic                   step_en = 1'b0;
  logic                   move_valid = 1'b0;
  logic                   move_ready;
  logic [PID_W-1:0]       move_pid = '0;
  logic [STEP_W-1:0]      move_steps = '0;
  logic [N*POS_W-1:0]     pos_flat;
  logic [N*LAP_W-1:0]     lap_flat;
  logic                   busy;
  logic                   move_done;
  logic                   move_err;
  logic                   land_shared;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  player_track_walker #(
    .N_PLAYERS(N), .TRACK_LEN(TLEN), .POS_W(POS_W),
    .PID_W(PID_W), .STEP_W(STEP_W), .LAP_W(LAP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .step_en(step_en),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_pid(move_pid), .move_steps(move_steps),
    .pos_flat(pos_flat), .lap_flat(lap_flat), .busy(busy),
    .move_done(move_done), .move_err(move_err), .land_shared(land_shared)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [PID_W-1:0] pid, input logic [STEP_W-1:0] steps);
    move_valid = 1'b1;
    move_pid   = pid;
    move_steps = steps;
    tick();
    move_valid = 1'b0;
  endtask

  task automatic run_move(input logic [PID_W-1:0] pid, input logic [STEP_W-1:0] steps,
                          output int cyc);
    issue(pid, steps);
    cyc = 0;
    while (!move_done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (pos_flat !== '0 || lap_flat !== '0) begin
      n_fail++; $display("FAIL reset_state pos=%0d lap=%0d want 0/0", pos_flat, lap_flat);
    end
    n_cmp++;
    if ({busy, move_done, move_err, land_shared} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, move_done, move_err, land_shared});
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (move_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", move_ready);
    end
  endtask

  task automatic test_reset_mid_walk();
    step_en = 1'b1;
    issue(2'd1, 3'd5);
    tick();
    tick();
    n_cmp++;
    if (pos_flat !== 15'(2 << 5) || busy !== 1'b1) begin
      n_fail++; $display("FAIL midwalk_pre pos=%0d busy=%b want 64/1", pos_flat, busy);
    end
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (pos_flat !== '0 || busy !== 1'b0 || move_done !== 1'b0) begin
      n_fail++; $display("FAIL midwalk_async pos=%0d busy=%b done=%b want 0/0/0", pos_flat, busy, move_done);
    end
    step_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (move_ready !== 1'b1 || pos_flat !== '0) begin
      n_fail++; $display("FAIL midwalk_ready ready=%b pos=%0d want 1/0", move_ready, pos_flat);
    end
  endtask

  task automatic test_basic_walk();
    step_en = 1'b1;
    issue(2'd1, 3'd5);
    n_cmp++;
    if (busy !== 1'b1 || move_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy busy=%b ready=%b want 1/0", busy, move_ready);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++;
      if (pos_flat !== 15'(i << 5) || move_done !== (i == 5)) begin
        n_fail++; $display("FAIL basic_step%0d pos=%0d done=%b want %0d/%b", i, pos_flat, move_done, i << 5, i == 5);
      end
    end
    n_cmp++;
    if (land_shared !== 1'b0 || move_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done shared=%b err=%b busy=%b want 0/0/0", land_shared, move_err, busy);
    end
    tick();
    n_cmp++;
    if (move_done !== 1'b0 || move_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_after done=%b ready=%b want 0/1", move_done, move_ready);
    end
    step_en = 1'b0;
  endtask

  task automatic test_wrap();
    int cyc;
    int exp_pos [4];
    step_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      run_move(2'd0, 3'd7, cyc);
      n_cmp++;
      if (move_done !== 1'b1) begin
        n_fail++; $display("FAIL wrap_setup%0d done=%b after %0d cycles want 1", r, move_done, cyc);
      end
      tick();
    end
    n_cmp++;
    if (pos_flat !== 15'((5 << 5) | 21) || lap_flat !== '0) begin
      n_fail++; $display("FAIL wrap_pre pos=%0d lap=%0d want 181/0", pos_flat, lap_flat);
    end
    exp_pos = '{22, 23, 0, 1};
    issue(2'd0, 3'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (pos_flat !== 15'((5 << 5) | exp_pos[i]) || lap_flat !== 12'(i >= 2)) begin
        n_fail++; $display("FAIL wrap_step%0d pos=%0d lap=%0d want %0d/%0d", i, pos_flat, lap_flat, (5 << 5) | exp_pos[i], i >= 2);
      end
    end
    n_cmp++;
    if (move_done !== 1'b1 || land_shared !== 1'b0) begin
      n_fail++; $display("FAIL wrap_done done=%b shared=%b want 1/0", move_done, land_shared);
    end
    tick();
    step_en = 1'b0;
  endtask

  task automatic test_shared();
    int cyc;
    step_en = 1'b1;
    run_move(2'd2, 3'd5, cyc);
    n_cmp++;
    if (move_done !== 1'b1 || land_shared !== 1'b1 || move_err !== 1'b0) begin
      n_fail++; $display("FAIL shared_done done=%b shared=%b err=%b want 1/1/0", move_done, land_shared, move_err);
    end
    n_cmp++;
    if (pos_flat !== 15'((5 << 10) | (5 << 5) | 1)) begin
      n_fail++; $display("FAIL shared_pos got %0d want 5281", pos_flat);
    end
    tick();
    n_cmp++;
    if (land_shared !== 1'b0) begin
      n_fail++; $display("FAIL shared_after got %b want 0", land_shared);
    end
    step_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    step_en = 1'b1;
    issue(2'd1, 3'd0);
    n_cmp++;
    if (move_done !== 1'b1 || move_err !== 1'b0 || land_shared !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_steps done=%b err=%b shared=%b busy=%b want 1/0/1/0", move_done, move_err, land_shared, busy);
    end
    n_cmp++;
    if (move_ready !== 1'b0) begin
      n_fail++; $display("FAIL done_ready got %b want 0", move_ready);
    end
    tick();
    n_cmp++;
    if (move_ready !== 1'b1 || move_done !== 1'b0) begin
      n_fail++; $display("FAIL idle_again ready=%b done=%b want 1/0", move_ready, move_done);
    end
    issue(2'd3, 3'd4);
    n_cmp++;
    if (move_done !== 1'b1 || move_err !== 1'b1 || land_shared !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_pid done=%b err=%b shared=%b busy=%b want 1/1/0/0", move_done, move_err, land_shared, busy);
    end
    tick();
    tick();
    n_cmp++;
    if (pos_flat !== 15'((5 << 10) | (5 << 5) | 1) || lap_flat !== 12'd1 || move_err !== 1'b0) begin
      n_fail++; $display("FAIL bad_pid_pos pos=%0d lap=%0d err=%b want 5281/1/0", pos_flat, lap_flat, move_err);
    end
    step_en = 1'b0;
  endtask

  task automatic test_clr();
    issue(2'd0, 3'd7);
    for (int i = 0; i < 6; i++) begin
      step_en = (i % 3 == 0);
      tick();
    end
    step_en = 1'b0;
    n_cmp++;
    if (pos_flat !== 15'((5 << 10) | (5 << 5) | 3) || busy !== 1'b1) begin
      n_fail++; $display("FAIL clr_gapped pos=%0d busy=%b want 5283/1", pos_flat, busy);
    end
    clr = 1'b1;
    #1;
    n_cmp++;
    if (move_ready !== 1'b0) begin
      n_fail++; $display("FAIL clr_ready_low got %b want 0", move_ready);
    end
    tick();
    n_cmp++;
    if (pos_flat !== '0 || lap_flat !== '0 || busy !== 1'b0 || move_done !== 1'b0) begin
      n_fail++; $display("FAIL clr_state pos=%0d lap=%0d busy=%b done=%b want 0/0/0/0", pos_flat, lap_flat, busy, move_done);
    end
    move_valid = 1'b1;
    move_pid   = 2'd1;
    move_steps = 3'd2;
    tick();
    move_valid = 1'b0;
    clr        = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || move_done !== 1'b0 || move_ready !== 1'b1) begin
      n_fail++; $display("FAIL clr_block busy=%b done=%b ready=%b want 0/0/1", busy, move_done, move_ready);
    end
    step_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (move_done !== 1'b0 || pos_flat !== '0) begin
        n_fail++; $display("FAIL clr_quiet%0d done=%b pos=%0d want 0/0", i, move_done, pos_flat);
      end
    end
    step_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_walk();
    test_basic_walk();
    test_wrap();
    test_shared();
    test_back_to_back();
    test_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
